mult_rr_scheduler: RTL and testbench
====================================

// Module: mult_rr_scheduler
// PURPOSE
//   Shares one multi-cycle generic_mult instance between N_REQ requesters.
//   Round-robin arbitration; one operation in flight at a time.
//   Drives the multiplier en/precision/jia/yi/valid inputs and waits for its ready.
//   Returns each product with the requester id on a single valid/ready response port.
// PARAMETERS
//   N_REQ          4   number of requesters (2..16)
//   MAX_PRECISION  32  operand width; matches `MAX_PRECISION of generic_mult
//   TIMEOUT        64  maximum BUSY cycles before the op is aborted with rsp_err
//   ID_W           clog2(N_REQ), localparam
// PORTS
//   clk            in   1                    clock
//   rst_n          in   1                    async active-low reset
//   req_valid      in   N_REQ                per-requester request
//   req_precision  in   6*N_REQ              packed per-requester precision (4/8/16/32)
//   req_jia        in   MAX_PRECISION*N_REQ  packed signed operand A (pre-sign-extended)
//   req_yi         in   MAX_PRECISION*N_REQ  packed signed operand B (pre-sign-extended)
//   req_ready      out  N_REQ                one-hot accept pulse
//   rsp_valid      out  1                    result available
//   rsp_ready      in   1                    consumer accepts result
//   rsp_id         out  ID_W                 index of the granted requester
//   rsp_zi         out  2*MAX_PRECISION      signed product
//   rsp_err        out  1                    bad precision or timeout; rsp_zi=0
//   m_en           out  1                    multiplier clock-gate enable
//   m_precision    out  6                    to generic_mult precision
//   m_jia, m_yi    out  MAX_PRECISION        to generic_mult operands
//   m_valid        out  1                    to generic_mult valid
//   m_zi           in   2*MAX_PRECISION      from generic_mult product
//   m_ready        in   1                    from generic_mult ready
// BEHAVIOUR
//   Reset (async, immediate): state=IDLE; rr_ptr=0; all outputs 0.
//   IDLE: the winner is the first req_valid bit at or after rr_ptr, wrapping modulo N_REQ.
//     req_ready[winner]=1 combinationally for this cycle only; all other bits 0.
//     Capture the winner's operands, precision and id.
//     Precision in {4,8,16,32}: go to BUSY.
//     Any other precision: go to RESP with rsp_err=1 and rsp_zi=0; the multiplier is not touched.
//     No requests: stay in IDLE.
//   BUSY: m_en=1 and m_valid=1; m_* held stable from the captured registers.
//     Cycle counter starts at 0. m_ready is ignored in the first BUSY cycle (masks stale ready).
//     From the second cycle on, when m_ready=1: register m_zi into rsp_zi, rsp_err=0, go to RESP.
//     If the counter reaches TIMEOUT-1 without ready: rsp_zi=0, rsp_err=1, go to RESP.
//   RESP: rsp_valid=1; rsp_id, rsp_zi and rsp_err held stable; m_valid=0, m_en=0.
//     On rsp_valid & rsp_ready: rr_ptr=(rsp_id+1) mod N_REQ, go to IDLE.
//     rsp_ready=0 stalls indefinitely; no new grant while stalled.
//   Latency: grant to rsp_valid = multiplier latency + 1 cycle.
//     Minimum op period is 4 cycles (IDLE, BUSY x2, RESP).
//   A requester must hold req_valid and operands until its req_ready pulse.
//     Dropping req_valid before the grant withdraws the request.
//   req_valid changing during BUSY/RESP has no effect until the next IDLE.
//   Width: operands pass through unmodified; rsp_zi is the full 2*MAX_PRECISION m_zi.
//   Reset mid-operation: everything clears immediately and the in-flight op is lost.
//     The multiplier sees m_valid=0 and m_en=0 immediately.
//   N_REQ not a power of 2: rr_ptr wraps from N_REQ-1 to 0.
// TESTING
//   1. Single op: req0, prec 8, jia=8, yi=31
//        -> req_ready[0] pulses once; rsp_zi=248, rsp_id=0, rsp_err=0.
//   2. Signed: req2, prec 8, jia=-8, yi=31
//        -> rsp_zi=-248 (sign-extended 64b), rsp_id=2.
//   3. All 4 requesters held valid
//        -> grant order 0,1,2,3,0; each granted exactly once per round.
//   4. prec=12 on req1 -> rsp_err=1, rsp_zi=0, m_valid never asserted.
//   5. Stuck multiplier (m_ready tied 0) -> rsp_err=1 after 64 BUSY cycles.
//   6. Backpressure: rsp_ready=0 for 10 cycles -> rsp fields stable, no req_ready pulses.
//      Reset asserted during BUSY -> m_valid=0 and rsp_valid=0 immediately, rr_ptr=0.

Source files
------------

// File: rtl/mult_rr_scheduler.sv
// Round-robin front end that shares one multi-cycle generic_mult between N_REQ requesters.
// One operation in flight; results return with the requester id on a valid/ready port.
module mult_rr_scheduler #(
    parameter int N_REQ         = 4,
    parameter int MAX_PRECISION = 32,
    parameter int TIMEOUT       = 64,
    localparam int ID_W         = $clog2(N_REQ)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [6*N_REQ-1:0]           req_precision,
    input  logic [MAX_PRECISION*N_REQ-1:0] req_jia,
    input  logic [MAX_PRECISION*N_REQ-1:0] req_yi,
    output logic [N_REQ-1:0]             req_ready,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [ID_W-1:0]              rsp_id,
    output logic [2*MAX_PRECISION-1:0]   rsp_zi,
    output logic                         rsp_err,
    output logic                         m_en,
    output logic [5:0]                   m_precision,
    output logic [MAX_PRECISION-1:0]     m_jia,
    output logic [MAX_PRECISION-1:0]     m_yi,
    output logic                         m_valid,
    input  logic [2*MAX_PRECISION-1:0]   m_zi,
    input  logic                         m_ready
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t            state, state_nxt;
    logic [ID_W-1:0]   rr_ptr, win_id, cap_id;
    logic              win_found, prec_ok, mult_done, mult_to;
    logic [5:0]        win_prec;
    logic [CNT_W-1:0]  cnt;
    logic [2*MAX_PRECISION-1:0] zi_q;
    logic              err_q;

    // Scan from highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        int idx;
        win_found = 1'b0;
        win_id    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = int'(rr_ptr) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (req_valid[idx]) begin
                win_found = 1'b1;
                win_id    = ID_W'(idx);
            end
        end
    end

    assign win_prec = req_precision[win_id*6 +: 6];
    assign prec_ok  = (win_prec == 6'd4) || (win_prec == 6'd8) ||
                      (win_prec == 6'd16) || (win_prec == 6'd32);

    // First BUSY cycle ignores m_ready so a stale ready from the last op is not taken.
    assign mult_done = (cnt != '0) && m_ready;
    assign mult_to   = !mult_done && (cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = 1'b0;
        m_en      = 1'b0;
        m_valid   = 1'b0;
        case (state)
            IDLE: begin
                if (win_found && rst_n) begin
                    req_ready[win_id] = 1'b1;
                    state_nxt = prec_ok ? BUSY : RESP;
                end
            end
            BUSY: begin
                m_en    = 1'b1;
                m_valid = 1'b1;
                if (mult_done || mult_to) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            cap_id      <= '0;
            m_precision <= '0;
            m_jia       <= '0;
            m_yi        <= '0;
            zi_q        <= '0;
            err_q       <= 1'b0;
            cnt         <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        cap_id <= win_id;
                        zi_q   <= '0;
                        err_q  <= !prec_ok;
                        cnt    <= '0;
                        // A bad precision never reaches the multiplier pins.
                        if (prec_ok) begin
                            m_precision <= win_prec;
                            m_jia       <= req_jia[win_id*MAX_PRECISION +: MAX_PRECISION];
                            m_yi        <= req_yi[win_id*MAX_PRECISION +: MAX_PRECISION];
                        end
                    end
                end
                BUSY: begin
                    if (mult_done) begin
                        zi_q  <= m_zi;
                        err_q <= 1'b0;
                    end else if (mult_to) begin
                        zi_q  <= '0;
                        err_q <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready)
                        rr_ptr <= (cap_id == ID_W'(N_REQ - 1)) ? '0 : cap_id + ID_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign rsp_id  = cap_id;
    assign rsp_zi  = zi_q;
    assign rsp_err = err_q;
endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Directed bench for mult_rr_scheduler with a small latency-programmable multiplier model.
module tb_mult_rr_scheduler;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [23:0] req_precision;
    logic [127:0] req_jia, req_yi;
    logic [3:0]  req_ready;
    logic        rsp_valid, rsp_ready;
    logic [1:0]  rsp_id;
    logic [63:0] rsp_zi;
    logic        rsp_err;
    logic        m_en, m_valid, m_ready;
    logic [5:0]  m_precision;
    logic [31:0] m_jia, m_yi;
    logic [63:0] m_zi;

    int errors = 0;
    int checks = 0;
    int lat    = 2;
    bit stuck  = 1'b0;
    int mcnt   = 0;
    int mval_cnt = 0;
    logic [3:0] grants[$];

    mult_rr_scheduler #(.N_REQ(4), .MAX_PRECISION(32), .TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_precision(req_precision),
        .req_jia(req_jia), .req_yi(req_yi), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_zi(rsp_zi), .rsp_err(rsp_err),
        .m_en(m_en), .m_precision(m_precision), .m_jia(m_jia), .m_yi(m_yi),
        .m_valid(m_valid), .m_zi(m_zi), .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    // Multiplier model: ready once m_valid has been high for lat cycles.
    always @(posedge clk) mcnt <= m_valid ? mcnt + 1 : 0;
    assign m_ready = !stuck && m_valid && (mcnt >= lat);
    assign m_zi = $signed({{32{m_jia[31]}}, m_jia}) * $signed({{32{m_yi[31]}}, m_yi});

    always @(negedge clk) begin
        #2;
        if (req_ready != 4'b0) grants.push_back(req_ready);
        if (m_valid) mval_cnt++;
    end

    task automatic set_req(input int id, input logic [5:0] prec, input logic [31:0] a, input logic [31:0] b);
        req_valid[id] = 1'b1;
        req_precision[id*6 +: 6] = prec;
        req_jia[id*32 +: 32] = a;
        req_yi[id*32 +: 32]  = b;
    endtask

    task automatic wait_rsp(output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (ok == 1'b0) begin
                @(negedge clk);
                cyc++;
                if (rsp_valid) ok = 1'b1;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rsp_wait: rsp_valid=%0b after %0d cycles, required 1", rsp_valid, cyc);
        end
    endtask

    task automatic accept();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_req(0, 6'd8, 32'd1, 32'd1);
        set_req(2, 6'd8, 32'd1, 32'd1);
        repeat (2) @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, m_valid, m_en, rsp_err} !== 8'b0) begin
            errors++;
            $display("FAIL reset_ctl: got %b, required 00000000", {req_ready, rsp_valid, m_valid, m_en, rsp_err});
        end
        checks++;
        if ({rsp_zi, rsp_id, m_jia, m_yi, m_precision} !== '0) begin
            errors++;
            $display("FAIL reset_data: rsp_zi=%h rsp_id=%0d m_jia=%h, required all 0", rsp_zi, rsp_id, m_jia);
        end
        req_valid = '0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int cyc; bit ok;
        set_req(0, 6'd8, 32'd8, 32'd31);
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL single_grant: req_ready=%b, required 0001", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        checks++;
        if ({m_valid, m_en, m_precision, m_jia, m_yi} !== {1'b1, 1'b1, 6'd8, 32'd8, 32'd31}) begin
            errors++; $display("FAIL single_mdrive: m_valid=%b prec=%0d jia=%0d yi=%0d, required 1 8 8 31", m_valid, m_precision, m_jia, m_yi);
        end
        wait_rsp(cyc, ok);
        checks++;
        if (cyc !== 3) begin
            errors++; $display("FAIL single_latency: %0d cycles after grant+1, required 3", cyc);
        end
        checks++;
        if ({rsp_zi, rsp_id, rsp_err} !== {64'd248, 2'd0, 1'b0}) begin
            errors++; $display("FAIL single_rsp: zi=%0d id=%0d err=%b, required 248 0 0", rsp_zi, rsp_id, rsp_err);
        end
        checks++;
        if (grants.size() != 1) begin
            errors++; $display("FAIL single_pulses: %0d grant pulses, required 1", grants.size());
        end
        accept();
    endtask

    task automatic test_signed();
        int cyc; bit ok;
        set_req(2, 6'd8, 32'hFFFF_FFF8, 32'd31);
        @(negedge clk);
        req_valid = '0;
        wait_rsp(cyc, ok);
        checks++;
        if ({rsp_zi, rsp_id, rsp_err} !== {64'hFFFF_FFFF_FFFF_FF08, 2'd2, 1'b0}) begin
            errors++; $display("FAIL signed_rsp: zi=%h id=%0d err=%b, required ffffffffffffff08 2 0", rsp_zi, rsp_id, rsp_err);
        end
        accept();
    endtask

    task automatic test_round_robin();
        int cyc; bit ok;
        logic [1:0]  exp_id [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [63:0] exp_zi [5] = '{64'd3, 64'd6, 64'd9, 64'd12, 64'd3};
        logic [3:0]  exp_gr [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        grants.delete();
        for (int i = 0; i < 4; i++) set_req(i, 6'd8, 32'(i + 1), 32'd3);
        for (int k = 0; k < 5; k++) begin
            wait_rsp(cyc, ok);
            checks++;
            if ({rsp_id, rsp_zi} !== {exp_id[k], exp_zi[k]}) begin
                errors++; $display("FAIL rr_rsp%0d: id=%0d zi=%0d, required %0d %0d", k, rsp_id, rsp_zi, exp_id[k], exp_zi[k]);
            end
            if (k == 4) req_valid = '0;
            accept();
        end
        checks++;
        if (grants.size() != 5) begin
            errors++; $display("FAIL rr_count: %0d grants, required 5", grants.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (grants[k] !== exp_gr[k]) begin
                    errors++; $display("FAIL rr_order%0d: req_ready=%b, required %b", k, grants[k], exp_gr[k]);
                end
            end
        end
    endtask

    task automatic test_bad_precision();
        int cyc; bit ok;
        mval_cnt = 0;
        set_req(1, 6'd12, 32'd5, 32'd5);
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++; $display("FAIL badprec_grant: req_ready=%b, required 0010", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++; $display("FAIL badprec_latency: rsp_valid=%b one cycle after grant, required 1", rsp_valid);
        end
        wait_rsp(cyc, ok);
        checks++;
        if ({rsp_zi, rsp_id, rsp_err} !== {64'd0, 2'd1, 1'b1}) begin
            errors++; $display("FAIL badprec_rsp: zi=%h id=%0d err=%b, required 0 1 1", rsp_zi, rsp_id, rsp_err);
        end
        accept();
        checks++;
        if (mval_cnt != 0) begin
            errors++; $display("FAIL badprec_mvalid: m_valid high %0d cycles, required 0", mval_cnt);
        end
    endtask

    task automatic test_timeout();
        int cyc; bit ok;
        stuck = 1'b1;
        mval_cnt = 0;
        set_req(3, 6'd16, 32'd5, 32'd7);
        @(negedge clk);
        req_valid = '0;
        wait_rsp(cyc, ok);
        checks++;
        if (mval_cnt != 64) begin
            errors++; $display("FAIL timeout_busy: %0d BUSY cycles, required 64", mval_cnt);
        end
        checks++;
        if ({rsp_zi, rsp_id, rsp_err} !== {64'd0, 2'd3, 1'b1}) begin
            errors++; $display("FAIL timeout_rsp: zi=%h id=%0d err=%b, required 0 3 1", rsp_zi, rsp_id, rsp_err);
        end
        accept();
        stuck = 1'b0;
    endtask

    task automatic test_min_latency();
        int cyc; bit ok;
        lat = 0;
        set_req(0, 6'd4, 32'hFFFF_FFFD, 32'd5);
        @(negedge clk);
        req_valid = '0;
        wait_rsp(cyc, ok);
        checks++;
        if (cyc !== 2) begin
            errors++; $display("FAIL minlat_cycles: %0d, required 2 (stale ready masked)", cyc);
        end
        checks++;
        if ({rsp_zi, rsp_id, rsp_err} !== {64'hFFFF_FFFF_FFFF_FFF1, 2'd0, 1'b0}) begin
            errors++; $display("FAIL minlat_rsp: zi=%h id=%0d err=%b, required fffffffffffffff1 0 0", rsp_zi, rsp_id, rsp_err);
        end
        accept();
        lat = 2;
    endtask

    task automatic test_back_pressure();
        int cyc; bit ok;
        set_req(1, 6'd32, 32'h7FFF_FFFF, 32'd2);
        @(negedge clk);
        req_valid = '0;
        wait_rsp(cyc, ok);
        for (int i = 0; i < 4; i++) set_req(i, 6'd8, 32'd1, 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({rsp_valid, rsp_id, rsp_zi, rsp_err, req_ready} !== {1'b1, 2'd1, 64'h0000_0000_FFFF_FFFE, 1'b0, 4'b0}) begin
                errors++; $display("FAIL stall%0d: valid=%b id=%0d zi=%h err=%b req_ready=%b, required 1 1 fffffffe 0 0000",
                                   i, rsp_valid, rsp_id, rsp_zi, rsp_err, req_ready);
            end
        end
        req_valid = '0;
        accept();
    endtask

    task automatic test_reset_mid();
        int cyc; bit ok;
        set_req(2, 6'd8, 32'd3, 32'd3);
        @(negedge clk);
        req_valid = '0;
        checks++;
        if (m_valid !== 1'b1) begin
            errors++; $display("FAIL rstmid_busy: m_valid=%b, required 1", m_valid);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({m_valid, m_en, rsp_valid} !== 3'b000) begin
            errors++; $display("FAIL rstmid_clear: m_valid=%b m_en=%b rsp_valid=%b, required 000", m_valid, m_en, rsp_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        set_req(0, 6'd8, 32'd4, 32'd4);
        set_req(3, 6'd8, 32'd9, 32'd9);
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL rstmid_ptr: req_ready=%b, required 0001", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        wait_rsp(cyc, ok);
        checks++;
        if ({rsp_zi, rsp_id} !== {64'd16, 2'd0}) begin
            errors++; $display("FAIL rstmid_rsp: zi=%0d id=%0d, required 16 0", rsp_zi, rsp_id);
        end
        accept();
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = '0;
        req_precision = '0;
        req_jia = '0;
        req_yi = '0;
        rsp_ready = 1'b0;
        test_reset();
        grants.delete();
        test_single();
        test_signed();
        test_round_robin();
        test_bad_precision();
        test_timeout();
        test_min_latency();
        test_back_pressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
